// File: rtl/noc_pck_injector.sv
// -----------------------------------------------------------------------------
// noc_pck_injector
//
// Endpoint-side packet injector for one router local input port. A packet
// descriptor (one-hot VC, length in flits, head payload) is followed by a
// stream of payload words. The block cuts these into head/body/tail flits and
// writes them to the router. Each flit is sent only when the target VC has a
// free slot, so the router input buffer (B flits per VC) can never overflow.
//
// Ports
//   clk         in   1     clock
//   reset       in   1     synchronous active-low reset
//   pck_valid   in   1     descriptor valid
//   pck_ready   out  1     descriptor taken when pck_valid & pck_ready
//   pck_vc      in   V     one-hot target VC
//   pck_len     in   Lw    packet length in flits, head included
//   pck_hdr     in   Fpay  head-flit payload
//   data_valid  in   1     payload word valid
//   data_ready  out  1     payload word taken when data_valid & data_ready
//   data_in     in   Fpay  body/tail payload
//   flit_out    out  Fw    {head, tail, vc[V-1:0], payload[Fpay-1:0]}
//   flit_out_wr out  1     flit write strobe (one cycle after each commit)
//   credit_in   in   V     per-VC credit return, one pulse per freed slot
//   busy        out  1     packet in progress
//   credit_err  out  1     sticky: a credit came back to a full counter
//
// Parameter constraints: MIN_PCK_SIZE >= 1, MIN_PCK_SIZE <= MAX_PCK_SIZE and
// 2**Lw > MAX_PCK_SIZE.
// -----------------------------------------------------------------------------
module noc_pck_injector #(
    parameter int V            = 4,
    parameter int B            = 4,
    parameter int Fpay         = 32,
    parameter int MIN_PCK_SIZE = 2,
    parameter int MAX_PCK_SIZE = 16,
    parameter int Lw           = 5,
    localparam int Fw          = 2 + V + Fpay
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pck_valid,
    output logic            pck_ready,
    input  logic [V-1:0]    pck_vc,
    input  logic [Lw-1:0]   pck_len,
    input  logic [Fpay-1:0] pck_hdr,
    input  logic            data_valid,
    output logic            data_ready,
    input  logic [Fpay-1:0] data_in,
    output logic [Fw-1:0]   flit_out,
    output logic            flit_out_wr,
    input  logic [V-1:0]    credit_in,
    output logic            busy,
    output logic            credit_err
);

    localparam int CW = $clog2(B + 1);

    localparam logic [Lw-1:0] LEN_ONE = Lw'(1);
    localparam logic [Lw-1:0] LEN_MIN = Lw'(MIN_PCK_SIZE);
    localparam logic [Lw-1:0] LEN_MAX = Lw'(MAX_PCK_SIZE);
    localparam logic [CW-1:0] CRD_ONE = CW'(1);
    localparam logic [CW-1:0] CRD_MAX = CW'(B);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t          state;
    logic [V-1:0]    vc_q;
    logic [Fpay-1:0] hdr_q;
    logic [Lw-1:0]   len_q;   // clamped packet length
    logic [Lw-1:0]   rem_q;   // flits still to send after the head

    logic [CW-1:0]   credit_cnt [V];

    logic [Lw-1:0]   eff_len;
    logic            credit_ok;
    logic            head_commit;
    logic            body_commit;
    logic [V-1:0]    commit_vec;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        eff_len = pck_len;
        if (pck_len < LEN_MIN)
            eff_len = LEN_MIN;
        else if (pck_len > LEN_MAX)
            eff_len = LEN_MAX;
    end

    // Credit check uses only registered counters, so credit_in never reaches
    // data_ready combinationally; a credit returned this cycle helps next cycle.
    always_comb begin
        credit_ok = 1'b0;
        for (int v = 0; v < V; v++) begin
            if (vc_q[v] && (credit_cnt[v] != '0))
                credit_ok = 1'b1;
        end
    end

    assign head_commit = (state == HEAD) && credit_ok;
    assign body_commit = (state == BODY) && credit_ok && data_valid;
    assign commit_vec  = (head_commit || body_commit) ? vc_q : '0;

    assign pck_ready  = (state == IDLE);
    assign data_ready = (state == BODY) && credit_ok;
    assign busy       = (state != IDLE);

    // -------------------------------------------------------------------------
    // Per-VC credit counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: this array is a handful of small counters, not a RAM, so it
            // is reset explicitly; every slot must start at B.
            for (int v = 0; v < V; v++)
                credit_cnt[v] <= CRD_MAX;
            credit_err <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (commit_vec[v] && !credit_in[v]) begin
                    credit_cnt[v] <= credit_cnt[v] - CRD_ONE;
                end else if (!commit_vec[v] && credit_in[v]) begin
                    // A credit to a full counter means the router returned
                    // more than we sent: saturate and flag it.
                    if (credit_cnt[v] == CRD_MAX)
                        credit_err <= 1'b1;
                    else
                        credit_cnt[v] <= credit_cnt[v] + CRD_ONE;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Segmentation FSM with registered flit output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state       <= IDLE;
            vc_q        <= '0;
            hdr_q       <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            flit_out    <= '0;
            flit_out_wr <= 1'b0;
        end else begin
            flit_out_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (pck_valid) begin
                        vc_q  <= pck_vc;
                        hdr_q <= pck_hdr;
                        len_q <= eff_len;
                        state <= HEAD;
                    end
                end
                HEAD: begin
                    if (credit_ok) begin
                        flit_out    <= {1'b1, (len_q == LEN_ONE), vc_q, hdr_q};
                        flit_out_wr <= 1'b1;
                        if (len_q == LEN_ONE) begin
                            state <= IDLE;
                        end else begin
                            rem_q <= len_q - LEN_ONE;
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (body_commit) begin
                        flit_out    <= {1'b0, (rem_q == LEN_ONE), vc_q, data_in};
                        flit_out_wr <= 1'b1;
                        rem_q       <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_pck_injector.sv
// -----------------------------------------------------------------------------
// tb_noc_pck_injector
//
// Directed bench for noc_pck_injector. dut uses MIN_PCK_SIZE=2; dut1 shares
// the inputs but uses MIN_PCK_SIZE=1 and is only examined in the clamp test.
// Inputs change on the falling edge and outputs are sampled there too. A flit
// is stamped with the number of the rising edge at which the router samples
// its strobe; a descriptor is stamped with the rising edge that accepts it.
// -----------------------------------------------------------------------------
module tb_noc_pck_injector;

    localparam int V    = 4;
    localparam int B    = 4;
    localparam int FPAY = 32;
    localparam int LW   = 5;
    localparam int FW   = 2 + V + FPAY;

    typedef struct {
        int            stamp;
        logic [FW-1:0] flit;
    } rec_t;

    logic            clk        = 1'b0;
    logic            reset      = 1'b0;
    logic            pck_valid  = 1'b0;
    logic [V-1:0]    pck_vc     = '0;
    logic [LW-1:0]   pck_len    = '0;
    logic [FPAY-1:0] pck_hdr    = '0;
    logic            data_valid = 1'b0;
    logic [FPAY-1:0] data_in    = '0;
    logic [V-1:0]    credit_in  = '0;

    logic            pck_ready, data_ready, flit_out_wr, busy, credit_err;
    logic [FW-1:0]   flit_out;
    logic            pck_ready1, data_ready1, flit_out_wr1, busy1, credit_err1;
    logic [FW-1:0]   flit_out1;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    rec_t mon_q[$];
    rec_t mon1_q[$];
    logic [FPAY-1:0] data_q[$];
    logic take_pending = 1'b0;

    noc_pck_injector #(.V(V), .B(B), .Fpay(FPAY), .MIN_PCK_SIZE(2),
                       .MAX_PCK_SIZE(16), .Lw(LW)) dut (
        .clk(clk), .reset(reset),
        .pck_valid(pck_valid), .pck_ready(pck_ready), .pck_vc(pck_vc),
        .pck_len(pck_len), .pck_hdr(pck_hdr),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_out_wr(flit_out_wr), .credit_in(credit_in),
        .busy(busy), .credit_err(credit_err)
    );

    noc_pck_injector #(.V(V), .B(B), .Fpay(FPAY), .MIN_PCK_SIZE(1),
                       .MAX_PCK_SIZE(16), .Lw(LW)) dut1 (
        .clk(clk), .reset(reset),
        .pck_valid(pck_valid), .pck_ready(pck_ready1), .pck_vc(pck_vc),
        .pck_len(pck_len), .pck_hdr(pck_hdr),
        .data_valid(data_valid), .data_ready(data_ready1), .data_in(data_in),
        .flit_out(flit_out1), .flit_out_wr(flit_out_wr1), .credit_in(credit_in),
        .busy(busy1), .credit_err(credit_err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Flit collectors
    always @(negedge clk) begin
        if (flit_out_wr === 1'b1)
            mon_q.push_back('{stamp: cyc + 1, flit: flit_out});
        if (flit_out_wr1 === 1'b1)
            mon1_q.push_back('{stamp: cyc + 1, flit: flit_out1});
    end

    // Payload source: always offers the head of data_q to dut
    always @(negedge clk) begin
        if (take_pending && (data_q.size() > 0))
            void'(data_q.pop_front());
        data_valid   = (data_q.size() != 0);
        data_in      = data_valid ? data_q[0] : '0;
        take_pending = data_valid && data_ready && reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares",
                 n_vec, n_bad);
        $fatal(1);
    end

    function automatic logic [FW-1:0] mk(input logic h, input logic t,
                                         input logic [V-1:0] vc,
                                         input logic [FPAY-1:0] p);
        return {h, t, vc, p};
    endfunction

    function automatic rec_t get_rec(input int i);
        rec_t r;
        r.stamp = -1;
        r.flit  = '0;
        if (i < mon_q.size())
            r = mon_q[i];
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Drivers (all called and returning at a falling edge)
    // -------------------------------------------------------------------------
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            credit_in = '0;
        end
    endtask

    task automatic do_reset();
        pck_valid = 1'b0;
        credit_in = '0;
        reset     = 1'b0;
        @(negedge clk);
        data_q.delete();
        @(negedge clk);
        reset = 1'b1;
        mon_q.delete();
        mon1_q.delete();
    endtask

    task automatic do_desc(input logic [V-1:0] vc, input logic [LW-1:0] len,
                           input logic [FPAY-1:0] hdr, output int n);
        bit got;
        got       = 1'b0;
        n         = -1;
        pck_vc    = vc;
        pck_len   = len;
        pck_hdr   = hdr;
        pck_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (pck_ready) begin
                n   = cyc + 1;
                got = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        pck_valid = 1'b0;
        n_vec++;
        if (!got) begin
            n_bad++;
            $display("FAIL desc_accept: pck_ready never seen, got 0 want 1");
        end
    endtask

    // Waits for cnt flits; with autoc the bench plays router and returns one
    // credit for every strobe it sees.
    task automatic wait_flits(input int cnt, input int budget, input bit autoc,
                              input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            credit_in = (autoc && flit_out_wr) ? flit_out[FW-3:FPAY] : '0;
            if (mon_q.size() >= cnt) break;
        end
        n_vec++;
        if (mon_q.size() < cnt) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d flits want %0d", name, mon_q.size(), cnt);
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_vec++;
        if (flit_out !== '0) begin
            n_bad++; $display("FAIL reset_flit_out: got %h want 0", flit_out);
        end
        n_vec++;
        if (flit_out_wr !== 1'b0) begin
            n_bad++; $display("FAIL reset_wr: got %b want 0", flit_out_wr);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_credit_err: got %b want 0", credit_err);
        end
        n_vec++;
        if (pck_ready !== 1'b1 || data_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b%b want 10", pck_ready, data_ready);
        end
        for (int v = 0; v < V; v++) begin
            n_vec++;
            if (dut.credit_cnt[v] !== 3'd4) begin
                n_bad++; $display("FAIL reset_credit[%0d]: got %0d want 4", v, dut.credit_cnt[v]);
            end
        end
    endtask

    task automatic test_single();
        int            n;
        rec_t          r;
        logic [FW-1:0] exp_f [3];
        do_reset();
        data_q.push_back(32'h1);
        data_q.push_back(32'h2);
        exp_f[0] = mk(1'b1, 1'b0, 4'b0010, 32'hAAAA0000);
        exp_f[1] = mk(1'b0, 1'b0, 4'b0010, 32'h1);
        exp_f[2] = mk(1'b0, 1'b1, 4'b0010, 32'h2);
        do_desc(4'b0010, 5'd3, 32'hAAAA0000, n);
        wait_flits(3, 30, 1'b0, "single");
        run_cycles(4);
        n_vec++;
        if (mon_q.size() != 3) begin
            n_bad++; $display("FAIL single_count: got %0d want 3", mon_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            r = get_rec(i);
            n_vec++;
            if (r.stamp !== n + 2 + i) begin
                n_bad++; $display("FAIL single_stamp[%0d]: got %0d want %0d", i, r.stamp, n + 2 + i);
            end
            n_vec++;
            if (r.flit !== exp_f[i]) begin
                n_bad++; $display("FAIL single_flit[%0d]: got %h want %h", i, r.flit, exp_f[i]);
            end
        end
        n_vec++;
        if (dut.credit_cnt[1] !== 3'd1) begin
            n_bad++; $display("FAIL single_credit1: got %0d want 1", dut.credit_cnt[1]);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_credit_stall();
        int   n, p;
        rec_t r;
        do_reset();
        for (int i = 1; i <= 5; i++) data_q.push_back(FPAY'(i));
        do_desc(4'b0001, 5'd6, 32'h5555_0000, n);
        wait_flits(4, 30, 1'b0, "stall");
        run_cycles(10);
        n_vec++;
        if (mon_q.size() != 4) begin
            n_bad++; $display("FAIL stall_count: got %0d want 4", mon_q.size());
        end
        n_vec++;
        if (data_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL stall_ready_busy: got %b%b want 01", data_ready, busy);
        end
        r = get_rec(3);
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b0, 4'b0001, 32'h3)) begin
            n_bad++; $display("FAIL stall_flit3: got %h want %h", r.flit, mk(1'b0, 1'b0, 4'b0001, 32'h3));
        end
        // One credit: counter rises at edge p, commit at p+1, strobe at p+2.
        credit_in = 4'b0001;
        p = cyc + 1;
        run_cycles(10);
        n_vec++;
        if (mon_q.size() != 5) begin
            n_bad++; $display("FAIL stall_resume_count: got %0d want 5", mon_q.size());
        end
        r = get_rec(4);
        n_vec++;
        if (r.stamp !== p + 2) begin
            n_bad++; $display("FAIL stall_resume_stamp: got %0d want %0d", r.stamp, p + 2);
        end
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b0, 4'b0001, 32'h4)) begin
            n_bad++; $display("FAIL stall_resume_flit: got %h want %h", r.flit, mk(1'b0, 1'b0, 4'b0001, 32'h4));
        end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        data_q.push_back(32'h77);
        do_desc(4'b0001, 5'd2, 32'h1234_5678, n);
        // In HEAD now: this credit lands on the same edge as the head commit.
        credit_in = 4'b0001;
        run_cycles(1);
        n_vec++;
        if (dut.credit_cnt[0] !== 3'd4) begin
            n_bad++; $display("FAIL simul_credit0: got %0d want 4", dut.credit_cnt[0]);
        end
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_bad++; $display("FAIL simul_no_err: got %b want 0", credit_err);
        end
        wait_flits(2, 30, 1'b0, "simul");
        run_cycles(2);
        n_vec++;
        if (dut.credit_cnt[0] !== 3'd3) begin
            n_bad++; $display("FAIL simul_credit0_after: got %0d want 3", dut.credit_cnt[0]);
        end
        credit_in = 4'b0100;
        run_cycles(1);
        n_vec++;
        if (dut.credit_cnt[2] !== 3'd4) begin
            n_bad++; $display("FAIL overflow_credit2: got %0d want 4", dut.credit_cnt[2]);
        end
        n_vec++;
        if (credit_err !== 1'b1) begin
            n_bad++; $display("FAIL overflow_err: got %b want 1", credit_err);
        end
        run_cycles(6);
        n_vec++;
        if (credit_err !== 1'b1) begin
            n_bad++; $display("FAIL overflow_err_sticky: got %b want 1", credit_err);
        end
        do_reset();
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_bad++; $display("FAIL overflow_err_reset: got %b want 0", credit_err);
        end
    endtask

    task automatic test_clamp();
        int   n;
        rec_t r;
        // len=1: dut (MIN=2) sends head+tail, dut1 (MIN=1) one head+tail flit
        do_reset();
        data_q.push_back(32'hBEEF);
        do_desc(4'b0001, 5'd1, 32'hC0DE_0001, n);
        wait_flits(2, 30, 1'b0, "clamp_min");
        run_cycles(4);
        n_vec++;
        if (mon_q.size() != 2) begin
            n_bad++; $display("FAIL clamp_min_count: got %0d want 2", mon_q.size());
        end
        r = get_rec(0);
        n_vec++;
        if (r.flit !== mk(1'b1, 1'b0, 4'b0001, 32'hC0DE_0001)) begin
            n_bad++; $display("FAIL clamp_min_head: got %h want %h", r.flit, mk(1'b1, 1'b0, 4'b0001, 32'hC0DE_0001));
        end
        r = get_rec(1);
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b1, 4'b0001, 32'hBEEF)) begin
            n_bad++; $display("FAIL clamp_min_tail: got %h want %h", r.flit, mk(1'b0, 1'b1, 4'b0001, 32'hBEEF));
        end
        n_vec++;
        if (mon1_q.size() != 1) begin
            n_bad++; $display("FAIL min1_count: got %0d want 1", mon1_q.size());
        end
        r.stamp = -1;
        r.flit  = '0;
        if (mon1_q.size() > 0) r = mon1_q[0];
        n_vec++;
        if (r.flit !== mk(1'b1, 1'b1, 4'b0001, 32'hC0DE_0001) || r.stamp !== n + 2) begin
            n_bad++; $display("FAIL min1_flit: got %h@%0d want %h@%0d", r.flit, r.stamp,
                              mk(1'b1, 1'b1, 4'b0001, 32'hC0DE_0001), n + 2);
        end
        n_vec++;
        if ({busy1, pck_ready1, data_ready1, credit_err1} !== 4'b0100) begin
            n_bad++; $display("FAIL min1_idle: got %b want 0100", {busy1, pck_ready1, data_ready1, credit_err1});
        end

        // len=31 clamps to 16 flits; credits are returned as the router would
        do_reset();
        for (int i = 0; i < 15; i++) data_q.push_back(32'h100 + FPAY'(i));
        do_desc(4'b0001, 5'd31, 32'hF00D_0000, n);
        wait_flits(16, 200, 1'b1, "clamp_max");
        run_cycles(6);
        n_vec++;
        if (mon_q.size() != 16) begin
            n_bad++; $display("FAIL clamp_max_count: got %0d want 16", mon_q.size());
        end
        r = get_rec(0);
        n_vec++;
        if (r.flit !== mk(1'b1, 1'b0, 4'b0001, 32'hF00D_0000)) begin
            n_bad++; $display("FAIL clamp_max_head: got %h want %h", r.flit, mk(1'b1, 1'b0, 4'b0001, 32'hF00D_0000));
        end
        r = get_rec(14);
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b0, 4'b0001, 32'h10D)) begin
            n_bad++; $display("FAIL clamp_max_f14: got %h want %h", r.flit, mk(1'b0, 1'b0, 4'b0001, 32'h10D));
        end
        r = get_rec(15);
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b1, 4'b0001, 32'h10E)) begin
            n_bad++; $display("FAIL clamp_max_tail: got %h want %h", r.flit, mk(1'b0, 1'b1, 4'b0001, 32'h10E));
        end
        n_vec++;
        if (busy !== 1'b0 || dut.credit_cnt[0] !== 3'd4 || credit_err !== 1'b0) begin
            n_bad++; $display("FAIL clamp_max_end: got busy=%b crd=%0d err=%b want busy=0 crd=4 err=0",
                              busy, dut.credit_cnt[0], credit_err);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        rec_t r;
        do_reset();
        for (int i = 1; i <= 7; i++) data_q.push_back(FPAY'(i));
        do_desc(4'b0001, 5'd8, 32'hDEAD_0000, n);
        wait_flits(3, 30, 1'b0, "rmid");
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_vec++;
        if ({busy, flit_out_wr, pck_ready} !== 3'b001) begin
            n_bad++; $display("FAIL rmid_state: got busy,wr,rdy=%b want 001", {busy, flit_out_wr, pck_ready});
        end
        n_vec++;
        if (flit_out !== '0) begin
            n_bad++; $display("FAIL rmid_flit_out: got %h want 0", flit_out);
        end
        for (int v = 0; v < V; v++) begin
            n_vec++;
            if (dut.credit_cnt[v] !== 3'd4) begin
                n_bad++; $display("FAIL rmid_credit[%0d]: got %0d want 4", v, dut.credit_cnt[v]);
            end
        end
        data_q.delete();
        mon_q.delete();
        run_cycles(2);
        data_q.push_back(32'h99);
        do_desc(4'b0100, 5'd2, 32'hCAFE_0000, n);
        wait_flits(2, 30, 1'b0, "rmid_next");
        r = get_rec(0);
        n_vec++;
        if (r.flit !== mk(1'b1, 1'b0, 4'b0100, 32'hCAFE_0000) || r.stamp !== n + 2) begin
            n_bad++; $display("FAIL rmid_next_head: got %h@%0d want %h@%0d", r.flit, r.stamp,
                              mk(1'b1, 1'b0, 4'b0100, 32'hCAFE_0000), n + 2);
        end
        r = get_rec(1);
        n_vec++;
        if (r.flit !== mk(1'b0, 1'b1, 4'b0100, 32'h99)) begin
            n_bad++; $display("FAIL rmid_next_tail: got %h want %h", r.flit, mk(1'b0, 1'b1, 4'b0100, 32'h99));
        end
    endtask

    task automatic test_back_to_back();
        int            n1, n2;
        rec_t          r;
        int            exp_s [4];
        logic [FW-1:0] exp_f [4];
        do_reset();
        data_q.push_back(32'hA1);
        data_q.push_back(32'hB1);
        // Head commits at n1+1, tail at n1+2; IDLE during the next cycle lets
        // the second descriptor in at n1+3, so its flits strobe at n1+5, n1+6.
        do_desc(4'b0001, 5'd2, 32'hAAAA_0001, n1);
        do_desc(4'b1000, 5'd2, 32'hBBBB_0002, n2);
        wait_flits(4, 40, 1'b0, "b2b");
        run_cycles(3);
        exp_s[0] = n1 + 2; exp_s[1] = n1 + 3; exp_s[2] = n1 + 5; exp_s[3] = n1 + 6;
        exp_f[0] = mk(1'b1, 1'b0, 4'b0001, 32'hAAAA_0001);
        exp_f[1] = mk(1'b0, 1'b1, 4'b0001, 32'hA1);
        exp_f[2] = mk(1'b1, 1'b0, 4'b1000, 32'hBBBB_0002);
        exp_f[3] = mk(1'b0, 1'b1, 4'b1000, 32'hB1);
        n_vec++;
        if (n2 !== n1 + 3) begin
            n_bad++; $display("FAIL b2b_accept2: got %0d want %0d", n2, n1 + 3);
        end
        for (int i = 0; i < 4; i++) begin
            r = get_rec(i);
            n_vec++;
            if (r.stamp !== exp_s[i]) begin
                n_bad++; $display("FAIL b2b_stamp[%0d]: got %0d want %0d", i, r.stamp, exp_s[i]);
            end
            n_vec++;
            if (r.flit !== exp_f[i]) begin
                n_bad++; $display("FAIL b2b_flit[%0d]: got %h want %h", i, r.flit, exp_f[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_stall();
        test_simultaneous();
        test_clamp();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
